// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared types and constants for the 8259 CPU-side bus master
package pic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    GAP
  } cyc_state_e;

  typedef enum logic [1:0] {
    STEP_ICW1,
    STEP_ICW2,
    STEP_ICW3,
    STEP_ICW4
  } icw_step_e;

  localparam int ICW1_MARK_BIT = 4;
  localparam int ICW1_IC4_BIT  = 0;
  localparam int OCW3_SEL_BIT  = 3;

  // The PIC recognises ICW1 by bit 4, so it is forced regardless of the caller's byte.
  function automatic logic [7:0] icw1_marked(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    r[ICW1_MARK_BIT] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/pic_bus_cycle.sv
// rtl/pic_bus_cycle.sv - one timed 8080-style read or write cycle on the PIC pins
module pic_bus_cycle
  import pic_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int GAP_CYCLES    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       write,
  input  logic       a0,
  input  logic [7:0] wdata,
  input  logic [7:0] data_i,
  output logic       rd_n,
  output logic       wr_n,
  output logic       cs_n,
  output logic       a0_o,
  output logic [7:0] data_o,
  output logic       data_oe,
  output logic       idle,
  output logic       done,
  output logic [7:0] rdata,
  output logic       rdata_valid
);

  localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] GAP_LAST    = 8'(GAP_CYCLES - 1);

  cyc_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       write_q, write_d;
  logic       a0_q, a0_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       load;
  logic       capture;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      a0_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      a0_q    <= a0_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // A new cycle may begin straight out of the last GAP clock so init steps run back-to-back.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = SETUP;
          load    = 1'b1;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = STROBE;
          cnt_d   = '0;
        end
      end
      STROBE: begin
        if (cnt_q == STROBE_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        state_d = GAP;
        cnt_d   = '0;
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = start ? SETUP : IDLE;
          load    = start;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign capture = (state_q == STROBE) && (cnt_q == STROBE_LAST) && !write_q;

  always_comb begin
    write_d = load ? write : write_q;
    a0_d    = load ? a0 : a0_q;
    wdata_d = load ? wdata : wdata_q;
    rdata_d = capture ? data_i : rdata_q;
  end

  always_comb begin
    cs_n        = 1'b1;
    rd_n        = 1'b1;
    wr_n        = 1'b1;
    data_oe     = 1'b0;
    rdata_valid = 1'b0;
    case (state_q)
      SETUP: begin
        cs_n    = 1'b0;
        data_oe = write_q;
      end
      STROBE: begin
        cs_n    = 1'b0;
        rd_n    = write_q;
        wr_n    = !write_q;
        data_oe = write_q;
      end
      HOLD: begin
        cs_n        = 1'b0;
        data_oe     = write_q;
        rdata_valid = !write_q;
      end
      default: begin
        cs_n = 1'b1;
      end
    endcase
  end

  assign a0_o   = a0_q;
  assign data_o = wdata_q;
  assign rdata  = rdata_q;
  assign idle   = (state_q == IDLE);
  assign done   = (state_q == GAP) && (cnt_q == GAP_LAST);

endmodule

// File: rtl/pic_cpu_bus_master.sv
// rtl/pic_cpu_bus_master.sv - command arbitration and ICW sequencer driving the 8259 CPU port
module pic_cpu_bus_master
  import pic_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int GAP_CYCLES    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_start,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  input  logic       acc_valid,
  output logic       acc_ready,
  input  logic       acc_write,
  input  logic       acc_a0,
  input  logic [7:0] acc_wdata,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       init_done,
  inout  wire  [7:0] cpu_data,
  output logic       RD,
  output logic       WR,
  output logic       A0,
  output logic       CS
);

  icw_step_e  step_q, step_d;
  logic       seq_q, seq_d;
  logic       init_done_q, init_done_d;
  logic [7:0] icw1_q, icw1_d, icw2_q, icw2_d, icw3_q, icw3_d, icw4_q, icw4_d;

  logic       cyc_start, cyc_write, cyc_a0;
  logic [7:0] cyc_wdata, cyc_data_o;
  logic       cyc_oe, cyc_idle, cyc_done;
  logic       in_idle, init_accept, acc_accept, last_step;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_q      <= STEP_ICW1;
      seq_q       <= 1'b0;
      init_done_q <= 1'b0;
      icw1_q      <= '0;
      icw2_q      <= '0;
      icw3_q      <= '0;
      icw4_q      <= '0;
    end else begin
      step_q      <= step_d;
      seq_q       <= seq_d;
      init_done_q <= init_done_d;
      icw1_q      <= icw1_d;
      icw2_q      <= icw2_d;
      icw3_q      <= icw3_d;
      icw4_q      <= icw4_d;
    end
  end

  assign in_idle     = cyc_idle && !seq_q;
  assign init_accept = in_idle && init_start;
  assign acc_ready   = rst_n && in_idle && !init_start;
  assign acc_accept  = acc_valid && acc_ready;
  assign last_step   = (step_q == STEP_ICW4) ||
                       ((step_q == STEP_ICW3) && !icw1_q[ICW1_IC4_BIT]);

  always_comb begin
    step_d      = step_q;
    seq_d       = seq_q;
    init_done_d = init_done_q;
    icw1_d      = icw1_q;
    icw2_d      = icw2_q;
    icw3_d      = icw3_q;
    icw4_d      = icw4_q;
    cyc_start   = 1'b0;
    cyc_write   = acc_write;
    cyc_a0      = acc_a0;
    cyc_wdata   = acc_wdata;
    if (init_accept) begin
      seq_d       = 1'b1;
      step_d      = STEP_ICW1;
      init_done_d = 1'b0;
      icw1_d      = icw1_marked(icw1);
      icw2_d      = icw2;
      icw3_d      = icw3;
      icw4_d      = icw4;
      cyc_start   = 1'b1;
      cyc_write   = 1'b1;
      cyc_a0      = 1'b0;
      cyc_wdata   = icw1_marked(icw1);
    end else if (acc_accept) begin
      cyc_start = 1'b1;
    end else if (seq_q && cyc_done) begin
      if (last_step) begin
        seq_d       = 1'b0;
        step_d      = STEP_ICW1;
        init_done_d = 1'b1;
      end else begin
        step_d    = icw_step_e'(step_q + 2'd1);
        cyc_start = 1'b1;
        cyc_write = 1'b1;
        cyc_a0    = 1'b1;
        case (step_q)
          STEP_ICW1: cyc_wdata = icw2_q;
          STEP_ICW2: cyc_wdata = icw3_q;
          default:   cyc_wdata = icw4_q;
        endcase
      end
    end
  end

  pic_bus_cycle #(
    .SETUP_CYCLES (SETUP_CYCLES),
    .STROBE_CYCLES(STROBE_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES)
  ) u_cycle (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (cyc_start),
    .write      (cyc_write),
    .a0         (cyc_a0),
    .wdata      (cyc_wdata),
    .data_i     (cpu_data),
    .rd_n       (RD),
    .wr_n       (WR),
    .cs_n       (CS),
    .a0_o       (A0),
    .data_o     (cyc_data_o),
    .data_oe    (cyc_oe),
    .idle       (cyc_idle),
    .done       (cyc_done),
    .rdata      (rd_data),
    .rdata_valid(rd_valid)
  );

  assign cpu_data  = cyc_oe ? cyc_data_o : 8'bzzzz_zzzz;
  assign busy      = !cyc_idle || seq_q;
  assign init_done = init_done_q;

endmodule
